// File: rtl/cpu_dmem_responder_if.sv
// rtl/cpu_dmem_responder_if.sv - CPU d-port and host load/dump port bundle
// Purpose: groups the CPU data-memory bus and the host req/ack port.
// Signals:
//   d_we, d_addr, d_dataout   CPU write strobe / address / write data
//   d_datain                  CPU read data (combinational from d_addr)
//   host_req, host_we         host request (held until ack/err) and direction
//   host_addr, host_wdata     host address / write data
//   host_ack, host_err        one-cycle completion / timeout pulses
//   host_rdata                host read data, valid with host_ack
// Modports: master = CPU + host side, slave = memory responder.
interface cpu_dmem_responder_if #(
  parameter int AW = 8,
  parameter int DW = 16
);
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_dataout;
  logic [DW-1:0] d_datain;
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_ack;
  logic          host_err;
  logic [DW-1:0] host_rdata;

  modport master (
    output d_we, d_addr, d_dataout, host_req, host_we, host_addr, host_wdata,
    input  d_datain, host_ack, host_err, host_rdata
  );

  modport slave (
    input  d_we, d_addr, d_dataout, host_req, host_we, host_addr, host_wdata,
    output d_datain, host_ack, host_err, host_rdata
  );
endinterface

// File: rtl/cpu_dmem_responder.sv
// rtl/cpu_dmem_responder.sv - data-memory responder for the CPU d-port with host load/dump port
// Purpose: 2**AW x DW RAM with a combinational CPU read port, a CPU write port and a
//   host req/ack port for preloading/inspecting memory. The CPU always has priority;
//   host writes wait while d_we is high and give up with host_err after HOST_TO cycles.
// Optional feature: define CPU_DMEM_MMIO_EN to map the top 4 addresses to I/O
//   (GPIO_OUT, synchronised GPIO_IN, free-running CYCLE counter, STATUS).
// Ports:
//   clock      system clock, all state on posedge
//   reset      asynchronous active-low reset
//   bus        slave modport: CPU d-port + host port
//   gpio_in    asynchronous external inputs (MMIO only)
//   gpio_out   GPIO output register (tied 0 without MMIO)
module cpu_dmem_responder #(
  parameter int AW      = 8,
  parameter int DW      = 16,
  parameter int HOST_TO = 15
) (
  input  logic                clock,
  input  logic                reset,
  cpu_dmem_responder_if.slave bus,
  input  logic [DW-1:0]       gpio_in,
  output logic [DW-1:0]       gpio_out
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    H_IDLE   = 2'd0,
    H_ACCESS = 2'd1,
    H_ACK    = 2'd2,
    H_ERR    = 2'd3
  } h_state_t;

  h_state_t      state_q, state_d;
  logic [3:0]    wait_q, wait_d;
  logic          h_we_q;
  logic [AW-1:0] h_addr_q;
  logic [DW-1:0] h_wdata_q;
  logic          host_rd_now;
  logic          host_wr_now;
  logic          ack_q;
  logic          err_q;
  logic [DW-1:0] rdata_q;

  // Address-decode results and I/O read data; constant when MMIO is compiled out.
  logic          cpu_io;
  logic          host_io;
  logic [DW-1:0] cpu_io_rd;
  logic [DW-1:0] host_io_rd;

  logic [DW-1:0] mem [0:DEPTH-1];

  // ---------------------------------------------------------------------------
  // Host FSM: next state and per-cycle access strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    host_rd_now = 1'b0;
    host_wr_now = 1'b0;
    case (state_q)
      H_IDLE: begin
        wait_d = '0;
        if (bus.host_req) state_d = H_ACCESS;
      end
      H_ACCESS: begin
        if (!h_we_q) begin
          // Reads use their own port, so the CPU can never block them.
          host_rd_now = 1'b1;
          state_d     = H_ACK;
        end else if (!bus.d_we) begin
          host_wr_now = 1'b1;
          state_d     = H_ACK;
        end else if (wait_q == 4'(HOST_TO - 1)) begin
          state_d = H_ERR;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      H_ACK:   state_d = H_IDLE;
      H_ERR:   state_d = H_IDLE;
      default: state_d = H_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= H_IDLE;
      wait_q    <= '0;
      h_we_q    <= 1'b0;
      h_addr_q  <= '0;
      h_wdata_q <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      ack_q   <= (state_d == H_ACK);
      err_q   <= (state_d == H_ERR);
      if (state_q == H_IDLE && bus.host_req) begin
        h_we_q    <= bus.host_we;
        h_addr_q  <= bus.host_addr;
        h_wdata_q <= bus.host_wdata;
      end
      // Sampled before this edge's RAM write lands, so a same-cycle CPU
      // write to the same word returns the old contents.
      if (host_rd_now) rdata_q <= host_io ? host_io_rd : mem[h_addr_q];
    end
  end

  assign bus.host_ack   = ack_q;
  assign bus.host_err   = err_q;
  assign bus.host_rdata = rdata_q;

  // ---------------------------------------------------------------------------
  // RAM: single write port shared by CPU and host (host only when d_we is low)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (bus.d_we && !cpu_io) begin
      mem[bus.d_addr] <= bus.d_dataout;
    end else if (host_wr_now && !host_io) begin
      mem[h_addr_q] <= h_wdata_q;
    end
  end

  assign bus.d_datain = cpu_io ? cpu_io_rd : mem[bus.d_addr];

`ifdef CPU_DMEM_MMIO_EN
  // ---------------------------------------------------------------------------
  // I/O window: top 4 words. idx 0 GPIO_OUT, 1 GPIO_IN, 2 CYCLE, 3 STATUS.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] gpio_q;
  logic [DW-1:0] gin_s1;
  logic [DW-1:0] gin_s2;
  logic [15:0]   cyc_q;
  logic          err_sticky_q;
  logic          io_we;
  logic [1:0]    io_idx;
  logic [DW-1:0] io_wdata;
  logic [DW-1:0] status_w;

  assign cpu_io  = &bus.d_addr[AW-1:2];
  assign host_io = &h_addr_q[AW-1:2];

  // CPU and host writes are mutually exclusive by construction, so one mux
  // selects the single I/O writer for the cycle.
  always_comb begin
    io_we    = 1'b0;
    io_idx   = bus.d_addr[1:0];
    io_wdata = bus.d_dataout;
    if (bus.d_we && cpu_io) begin
      io_we = 1'b1;
    end else if (host_wr_now && host_io) begin
      io_we    = 1'b1;
      io_idx   = h_addr_q[1:0];
      io_wdata = h_wdata_q;
    end
  end

  assign status_w = {{(DW-2){1'b0}}, err_sticky_q, (state_q != H_IDLE)};

  function automatic logic [DW-1:0] io_mux(input logic [1:0]    idx,
                                           input logic [DW-1:0] g_out,
                                           input logic [DW-1:0] g_in,
                                           input logic [DW-1:0] cyc,
                                           input logic [DW-1:0] st);
    case (idx)
      2'd0:    io_mux = g_out;
      2'd1:    io_mux = g_in;
      2'd2:    io_mux = cyc;
      default: io_mux = st;
    endcase
  endfunction

  assign cpu_io_rd  = io_mux(bus.d_addr[1:0], gpio_q, gin_s2, DW'(cyc_q), status_w);
  assign host_io_rd = io_mux(h_addr_q[1:0],   gpio_q, gin_s2, DW'(cyc_q), status_w);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      gpio_q       <= '0;
      gin_s1       <= '0;
      gin_s2       <= '0;
      cyc_q        <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      gin_s1 <= gpio_in;
      gin_s2 <= gin_s1;
      if (io_we && io_idx == 2'd0) gpio_q <= io_wdata;
      // A write to CYCLE takes precedence over the increment.
      if (io_we && io_idx == 2'd2) cyc_q <= '0;
      else                         cyc_q <= cyc_q + 16'd1;
      if (state_d == H_ERR)      err_sticky_q <= 1'b1;
      else if (state_d == H_ACK) err_sticky_q <= 1'b0;
    end
  end

  assign gpio_out = gpio_q;
`else
  logic unused_gpio_in;

  assign cpu_io         = 1'b0;
  assign host_io        = 1'b0;
  assign cpu_io_rd      = '0;
  assign host_io_rd     = '0;
  assign gpio_out       = '0;
  assign unused_gpio_in = ^gpio_in;
`endif

endmodule
